// File: rtl/mult_if.sv
// rtl/mult_if.sv - request/result bundle between a multiply requester and the mult core
interface mult_if;
  logic        start;
  logic        signed_op;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, signed_op, multiplicand, multiplier,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, signed_op, multiplicand, multiplier,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult.sv
// rtl/mult.sv - 32x32 sequential shift-add multiplier, 34-cycle fixed latency
// Optional MULT_SIGNED_EN: honour signed_op with magnitude/sign-fix; otherwise unsigned only.
module mult (
  input  logic   clk_i,
  input  logic   rst_ni,
  mult_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, CALC, SIGN} state_e;

  state_e      state_q;
  logic [31:0] mcand_q;
  logic [31:0] mplier_q;
  logic [63:0] acc_q;
  logic [4:0]  cnt_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        neg_q;

  logic [31:0] a_mag_d;
  logic [31:0] b_mag_d;
  logic        neg_d;
  logic [32:0] sum_d;
  logic [63:0] product_d;

`ifdef MULT_SIGNED_EN
  // 0x80000000 negates to itself, which is the correct unsigned magnitude.
  always_comb begin
    a_mag_d   = (bus.signed_op && bus.multiplicand[31]) ? (~bus.multiplicand + 32'd1)
                                                        : bus.multiplicand;
    b_mag_d   = (bus.signed_op && bus.multiplier[31]) ? (~bus.multiplier + 32'd1)
                                                      : bus.multiplier;
    neg_d     = bus.signed_op & (bus.multiplicand[31] ^ bus.multiplier[31]);
    product_d = neg_q ? (~acc_q + 64'd1) : acc_q;
  end
`else
  logic unused_signed_op;
  assign unused_signed_op = bus.signed_op;

  always_comb begin
    a_mag_d   = bus.multiplicand;
    b_mag_d   = bus.multiplier;
    neg_d     = 1'b0;
    product_d = acc_q;
  end
`endif

  assign sum_d = {1'b0, acc_q[63:32]} + {1'b0, (mplier_q[0] ? mcand_q : 32'd0)};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      mcand_q  <= 32'd0;
      mplier_q <= 32'd0;
      acc_q    <= 64'd0;
      cnt_q    <= 5'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      neg_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            mcand_q  <= a_mag_d;
            mplier_q <= b_mag_d;
            neg_q    <= neg_d;
            acc_q    <= 64'd0;
            cnt_q    <= 5'd0;
            busy_q   <= 1'b1;
            state_q  <= CALC;
          end
        end
        CALC: begin
          acc_q    <= {sum_d, acc_q[31:1]};
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q <= SIGN;
          end
        end
        SIGN: begin
          {hi_q, lo_q} <= product_d;
          done_q       <= 1'b1;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule
